// File: rtl/serial_adder_if.sv
// Host <-> serial adder bus: operation request, handshake and registered result.
// With SERIAL_ADDER_OVF_EN defined the bus also carries the signed-overflow flag ovf.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
`else
    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout
    );
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: a single full-adder cell walks the operands LSB
// first, one bit per clock, with the carry held in a flop between bits.
// Subtraction is a + ~b + 1, so cout = 1 means "no borrow".
// Optional macro SERIAL_ADDER_OVF_EN adds a registered two's-complement
// overflow flag (bus.ovf); without it no ovf logic exists.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] op_a_reg, op_a_next;
    logic [WIDTH-1:0] op_b_reg, op_b_next;
    logic [WIDTH-1:0] res_reg, res_next;
    logic [WIDTH-1:0] sum_reg, sum_next;
    logic             carry_reg, carry_next;
    logic             cout_reg, cout_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_reg, ovf_next;
`endif

    // The one full-adder cell, fed from the operand LSBs and the carry flop.
    logic bit_sum;
    logic bit_carry;
    assign bit_sum   = op_a_reg[0] ^ op_b_reg[0] ^ carry_reg;
    assign bit_carry = (op_a_reg[0] & op_b_reg[0]) |
                       (op_a_reg[0] & carry_reg)   |
                       (op_b_reg[0] & carry_reg);

    // Next-state and datapath: load on start from IDLE/DONE, shift one bit per ADD cycle.
    always_comb begin
        state_next = state_reg;
        op_a_next  = op_a_reg;
        op_b_next  = op_b_reg;
        res_next   = res_reg;
        sum_next   = sum_reg;
        carry_next = carry_reg;
        cout_next  = cout_reg;
        cnt_next   = cnt_reg;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_next   = ovf_reg;
`endif
        case (state_reg)
            IDLE, DONE: begin
                // DONE accepts a new start directly so back-to-back ops have no bubble.
                if (bus.start) begin
                    op_a_next  = bus.a;
                    op_b_next  = bus.sub ? ~bus.b : bus.b;
                    carry_next = bus.sub | bus.cin;
                    cnt_next   = '0;
                    state_next = ADD;
                end else begin
                    state_next = IDLE;
                end
            end
            ADD: begin
                op_a_next  = op_a_reg >> 1;
                op_b_next  = op_b_reg >> 1;
                carry_next = bit_carry;
                res_next   = {bit_sum, res_reg[WIDTH-1:1]};
                cnt_next   = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                    // Last bit is the MSB: publish the full result this edge.
                    sum_next   = {bit_sum, res_reg[WIDTH-1:1]};
                    cout_next  = bit_carry;
`ifdef SERIAL_ADDER_OVF_EN
                    // Carry into the MSB is the flop value; carry out is the new one.
                    ovf_next   = carry_reg ^ bit_carry;
`endif
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            op_a_reg  <= '0;
            op_b_reg  <= '0;
            res_reg   <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            cnt_reg   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            op_a_reg  <= op_a_next;
            op_b_reg  <= op_b_next;
            res_reg   <= res_next;
            sum_reg   <= sum_next;
            carry_reg <= carry_next;
            cout_reg  <= cout_next;
            cnt_reg   <= cnt_next;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_reg   <= ovf_next;
`endif
        end
    end

    assign bus.busy = (state_reg == ADD);
    assign bus.done = (state_reg == DONE);
    assign bus.sum  = sum_reg;
    assign bus.cout = cout_reg;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf  = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit and a 16-bit instance share clk/rst.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_serial_adder;

    logic clk;
    logic rst;

    serial_adder_if #(.WIDTH(8))  i8 ();
    serial_adder_if #(.WIDTH(16)) i16 ();

    serial_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(i8.slave));
    serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(i16.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [63:0] prev8  = '0;
    logic [63:0] prev16 = '0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One complete operation on either instance, then one idle cycle.
    task automatic run_op(input bit w16, input logic [63:0] av, input logic [63:0] bv,
                          input bit subv, input bit cinv,
                          input logic [63:0] exp_sum, input bit exp_cout, input string tag);
        int n;
        logic [63:0] prev;
        n    = w16 ? 16 : 8;
        prev = w16 ? prev16 : prev8;
        if (w16) begin
            i16.a = av[15:0]; i16.b = bv[15:0]; i16.sub = subv; i16.cin = cinv; i16.start = 1'b1;
        end else begin
            i8.a = av[7:0]; i8.b = bv[7:0]; i8.sub = subv; i8.cin = cinv; i8.start = 1'b1;
        end
        step();
        i8.start = 1'b0;
        i16.start = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (k != 0) step();
            check({tag, " busy"}, 64'(w16 ? i16.busy : i8.busy), 64'(1));
            check({tag, " done_low"}, 64'(w16 ? i16.done : i8.done), 64'(0));
            check({tag, " sum_held"}, w16 ? 64'(i16.sum) : 64'(i8.sum), prev);
        end
        step();
        check({tag, " done"}, 64'(w16 ? i16.done : i8.done), 64'(1));
        check({tag, " busy_low"}, 64'(w16 ? i16.busy : i8.busy), 64'(0));
        check({tag, " sum"}, w16 ? 64'(i16.sum) : 64'(i8.sum), exp_sum);
        check({tag, " cout"}, 64'(w16 ? i16.cout : i8.cout), 64'(exp_cout));
        if (w16) prev16 = exp_sum; else prev8 = exp_sum;
        step();
        check({tag, " done_pulse"}, 64'(w16 ? i16.done : i8.done), 64'(0));
        check({tag, " idle"}, 64'(w16 ? i16.busy : i8.busy), 64'(0));
        check({tag, " sum_kept"}, w16 ? 64'(i16.sum) : 64'(i8.sum), exp_sum);
    endtask

    initial begin
        rst = 1'b1;
        i8.start = 1'b0;  i8.sub = 1'b0;  i8.a = '0;  i8.b = '0;  i8.cin = 1'b0;
        i16.start = 1'b0; i16.sub = 1'b0; i16.a = '0; i16.b = '0; i16.cin = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("reset busy", 64'(i8.busy), 64'(0));
        check("reset done", 64'(i8.done), 64'(0));
        check("reset sum",  64'(i8.sum),  64'(0));
        check("reset cout", 64'(i8.cout), 64'(0));
`ifdef SERIAL_ADDER_OVF_EN
        check("reset ovf",  64'(i8.ovf),  64'(0));
`endif

        run_op(1'b0, 64'h5A, 64'h3C, 1'b0, 1'b0, 64'h96, 1'b0, "add_5a_3c");
        run_op(1'b0, 64'hFF, 64'h01, 1'b0, 1'b1, 64'h01, 1'b1, "add_ff_01_cin");
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf_ff_01", 64'(i8.ovf), 64'(0));
        run_op(1'b0, 64'h7F, 64'h01, 1'b0, 1'b0, 64'h80, 1'b0, "add_7f_01");
        check("ovf_7f_01", 64'(i8.ovf), 64'(1));
`endif
        run_op(1'b0, 64'h10, 64'h01, 1'b1, 1'b1, 64'h0F, 1'b1, "sub_10_01");
        run_op(1'b0, 64'h01, 64'h02, 1'b1, 1'b0, 64'hFF, 1'b0, "sub_01_02");

        // Start held through ADD with new operands, then restart from the DONE cycle.
        i8.a = 8'h12; i8.b = 8'h34; i8.sub = 1'b0; i8.cin = 1'b0; i8.start = 1'b1;
        step();
        check("hold busy", 64'(i8.busy), 64'(1));
        i8.a = 8'hAA; i8.b = 8'h55;
        for (int k = 1; k < 8; k++) begin
            step();
            check("hold busy_run", 64'(i8.busy), 64'(1));
            check("hold sum_held", 64'(i8.sum), prev8);
        end
        i8.a = 8'h01; i8.b = 8'h01;
        step();
        check("hold done", 64'(i8.done), 64'(1));
        check("hold sum", 64'(i8.sum), 64'h46);
        check("hold cout", 64'(i8.cout), 64'(0));
        step();
        i8.start = 1'b0;
        check("b2b busy", 64'(i8.busy), 64'(1));
        check("b2b done_low", 64'(i8.done), 64'(0));
        check("b2b sum_held", 64'(i8.sum), 64'h46);
        for (int k = 1; k < 8; k++) begin
            step();
            check("b2b busy_run", 64'(i8.busy), 64'(1));
            check("b2b done_early", 64'(i8.done), 64'(0));
        end
        step();
        check("b2b done", 64'(i8.done), 64'(1));
        check("b2b sum", 64'(i8.sum), 64'h02);
        prev8 = 64'h02;
        step();
        check("b2b done_pulse", 64'(i8.done), 64'(0));

        // Reset in the middle of an operation discards it.
        i8.a = 8'h5A; i8.b = 8'h3C; i8.sub = 1'b0; i8.cin = 1'b0; i8.start = 1'b1;
        step();
        i8.start = 1'b0;
        for (int k = 0; k < 3; k++) step();
        check("midrst busy_before", 64'(i8.busy), 64'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst busy", 64'(i8.busy), 64'(0));
        check("midrst done", 64'(i8.done), 64'(0));
        check("midrst sum",  64'(i8.sum),  64'(0));
        check("midrst cout", 64'(i8.cout), 64'(0));
        prev8 = '0;
        prev16 = '0;
        step();
        check("midrst idle", 64'(i8.busy), 64'(0));
        run_op(1'b0, 64'h03, 64'h04, 1'b0, 1'b0, 64'h07, 1'b0, "after_rst_03_04");

        // 16-bit instance: first a nonzero result, then a wrap-around.
        run_op(1'b1, 64'h1234, 64'h1111, 1'b0, 1'b0, 64'h2345, 1'b0, "w16_1234_1111");
        run_op(1'b1, 64'hFFFF, 64'h0001, 1'b0, 1'b0, 64'h0000, 1'b1, "w16_ffff_0001");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised bit-serial adder/subtractor: one full-adder cell reused over WIDTH clock cycles, LSB first.
- Successor to the single-bit combinational full adder; adds operand width, add/sub mode, a carry chain through a flop, and a start/done handshake.
- Used where area matters more than latency; the host issues one operation at a time and waits for done.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH)+1, bit-counter width; derived, not for override.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- sub  input  1  0 = add, 1 = subtract (a - b); latched with start.
- a  input  WIDTH  operand A; latched with start.
- b  input  WIDTH  operand B; latched with start.
- cin  input  1  carry-in for add mode; latched with start; ignored in sub mode.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  registered result; held until the next completion.
- cout  output  1  registered carry-out; in sub mode, 1 = no borrow.

Behaviour:
- Reset (rst high at a clk edge): state = IDLE; busy = 0, done = 0, sum = 0, cout = 0; operand shift registers, carry flop and counter cleared. Reset takes priority over every other input, including mid-operation, and the partial result is discarded.
- FSM states: IDLE, ADD, DONE.
- IDLE, start = 1 at edge E0:
  - load opA = a and opB = (sub ? ~b : b);
  - carry = (sub ? 1 : cin);
  - count = 0;
  - go to ADD; busy = 1 from E0.
- ADD, each edge E1..EWIDTH:
  - s = opA[0] ^ opB[0] ^ carry;
  - carry <= majority(opA[0], opB[0], carry);
  - opA and opB shift right by 1;
  - s shifts into the MSB of the internal result shift register;
  - count increments.
  - On the edge where count reaches WIDTH-1→WIDTH (edge EWIDTH): sum <= full result register including this bit, cout <= final carry, state <= DONE, busy <= 0, done <= 1.
- Latency: done and the new sum/cout are visible WIDTH edges after the start-sampling edge. WIDTH = 8 gives 8 cycles.
- DONE (exactly one cycle): done = 1.
  - If start = 1: behave as IDLE with start, so back-to-back operations have zero bubble. done drops, busy rises.
  - Otherwise: go to IDLE, done = 0.
- start while in ADD: ignored, no queueing. a, b, sub and cin changes during ADD have no effect.
- sum and cout change only on completion or reset. During busy they hold the previous result.
- Arithmetic is modulo 2^WIDTH. cout is bit WIDTH of a + b + cin (add) or a + ~b + 1 (sub).

Optional Feature:
- Macro SERIAL_ADDER_OVF_EN.
- Defined: extra output port ovf (output, 1 bit), the two's-complement signed-overflow flag.
  - ovf = carry into the MSB XOR carry out of the MSB, captured on the final ADD edge.
  - Registered alongside sum. Reset value 0. Holds until the next completion.
- Undefined: no ovf port and no related logic; all other behaviour identical.

Test Plan:
- WIDTH=8, add, a=0x5A, b=0x3C, cin=0, start pulse -> busy for 8 cycles, then done pulse; sum=0x96, cout=0.
- Add, a=0xFF, b=0x01, cin=1 -> sum=0x01, cout=1; with SERIAL_ADDER_OVF_EN: a=0x7F, b=0x01, cin=0 -> sum=0x80, ovf=1.
- Sub, a=0x10, b=0x01, cin=1 (ignored) -> sum=0x0F, cout=1; sub, a=0x01, b=0x02 -> sum=0xFF, cout=0.
- Start held high with new operands during ADD (a=0xAA, b=0x55) -> ignored; first result unaffected. Start asserted in the DONE cycle with a=0x01, b=0x01 -> second done exactly 8 cycles later, sum=0x02.
- rst asserted on the 4th ADD cycle of 0x5A+0x3C -> next cycle busy=0, done=0, sum=0x00, cout=0, state IDLE. A following start for 0x03+0x04 completes with sum=0x07.
- WIDTH=16 instance, add 0xFFFF+0x0001, cin=0 -> done after 16 cycles, sum=0x0000, cout=1; sum holds its previous value throughout busy.
